reset_sequencer: RTL

//  Ordered reset release for STAGES downstream reset domains (e.g. memory ctrl -> bus -> CPU -> periph).

---
 rtl/reset_seq_pkg.sv | 25 ++
 rtl/reset_sequencer_if.sv | 28 ++
 rtl/reset_seq_counter.sv | 26 ++
 rtl/reset_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the ordered reset-release sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        WAIT   = 2'd1,
        DONE   = 2'd2,
        FAULT  = 2'd3
    } reset_seq_state_t;

    // Counter must reach the largest limit without wrapping.
    function automatic int cnt_width(input int hold_cycles, input int ready_timeout,
                                     input int wdt_cycles);
        int m;
        m = hold_cycles;
        if (ready_timeout > m) m = ready_timeout;
        if (wdt_cycles > m) m = wdt_cycles;
        return $clog2(m + 1);
    endfunction

    function automatic int stage_width(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and its reset domains.
// Watchdog signals exist only when RESET_SEQ_WATCHDOG_EN is defined.
interface reset_sequencer_if #(
    parameter int STAGES = 4
) ();
    localparam int SW = reset_seq_pkg::stage_width(STAGES);

    logic              i_sw_reset;
    logic [STAGES-1:0] i_ready;
    logic [STAGES-1:0] o_reset;
    logic              o_done;
    logic              o_fault;
    logic [SW-1:0]     o_fault_stage;
`ifdef RESET_SEQ_WATCHDOG_EN
    logic              i_wdt_kick;
    logic              o_wdt_bite;

    modport master (output i_sw_reset, i_ready, i_wdt_kick,
                    input  o_reset, o_done, o_fault, o_fault_stage, o_wdt_bite);
    modport slave  (input  i_sw_reset, i_ready, i_wdt_kick,
                    output o_reset, o_done, o_fault, o_fault_stage, o_wdt_bite);
`else
    modport master (output i_sw_reset, i_ready,
                    input  o_reset, o_done, o_fault, o_fault_stage);
    modport slave  (input  i_sw_reset, i_ready,
                    output o_reset, o_done, o_fault, o_fault_stage);
`endif
endinterface

// File: rtl/reset_seq_counter.sv
// Clear/enable up-counter with terminal-count flag; saturates at limit-1.
module reset_seq_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);
    logic [WIDTH-1:0] count_r;

    assign tc = (count_r == (limit - WIDTH'(1)));

    // Count register: clear wins, holds once the terminal count is reached.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_r <= '0;
        end else if (en && !tc) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end
endmodule

// File: rtl/reset_sequencer.sv
// Ordered per-domain reset release with ready handshakes and timeout fault.
// Optional watchdog in DONE enabled by defining RESET_SEQ_WATCHDOG_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int STAGES        = 4,
    parameter int HOLD_CYCLES   = 4,
    parameter int READY_TIMEOUT = 1024,
    parameter int WDT_CYCLES    = 1048576
) (
    input logic               i_clock,
    input logic               i_reset,
    reset_sequencer_if.slave  bus
);
`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int CW = cnt_width(HOLD_CYCLES, READY_TIMEOUT, WDT_CYCLES);
`else
    localparam int CW = cnt_width(HOLD_CYCLES, READY_TIMEOUT, 1);
`endif
    localparam int SW = stage_width(STAGES);
    localparam logic [CW-1:0] HOLD_LIM   = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] TMO_LIM    = CW'(READY_TIMEOUT);
    localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);

    reset_seq_state_t  state_r, state_s;
    logic [SW-1:0]     stage_r, stage_s;
    logic [STAGES-1:0] reset_r, reset_s;
    logic              done_r, done_s;
    logic              fault_r, fault_s;
    logic [SW-1:0]     fstage_r, fstage_s;
    logic              cnt_clr_s, cnt_en_s, cnt_tc_s;
    logic [CW-1:0]     cnt_limit_s;

    assign cnt_limit_s = (state_r == ASSERT) ? HOLD_LIM : TMO_LIM;

    reset_seq_counter #(.WIDTH(CW)) u_seq_cnt (
        .clk   (i_clock),
        .rst   (i_reset),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .limit (cnt_limit_s),
        .tc    (cnt_tc_s)
    );

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam logic [CW-1:0] WDT_LIM = CW'(WDT_CYCLES);
    logic wdt_tc_s, wdt_clr_s, bite_s, bite_r;

    assign wdt_clr_s = (state_r != DONE) || bus.i_wdt_kick;

    reset_seq_counter #(.WIDTH(CW)) u_wdt_cnt (
        .clk   (i_clock),
        .rst   (i_reset),
        .clr   (wdt_clr_s),
        .en    (1'b1),
        .limit (WDT_LIM),
        .tc    (wdt_tc_s)
    );
    assign bus.o_wdt_bite = bite_r;
`endif

    // Next-state logic; software restart outranks ready and timeout.
    always_comb begin
        state_s   = state_r;
        stage_s   = stage_r;
        done_s    = done_r;
        fault_s   = fault_r;
        fstage_s  = fstage_r;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
        bite_s    = 1'b0;
`endif
        if (bus.i_sw_reset) begin
            state_s   = ASSERT;
            stage_s   = '0;
            done_s    = 1'b0;
            fault_s   = 1'b0;
            fstage_s  = '0;
            cnt_clr_s = 1'b1;
        end else begin
            case (state_r)
                ASSERT: begin
                    if (cnt_tc_s) begin
                        state_s   = WAIT;
                        stage_s   = '0;
                        cnt_clr_s = 1'b1;
                    end else begin
                        cnt_en_s  = 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.i_ready[stage_r]) begin
                        cnt_clr_s = 1'b1;
                        if (stage_r == LAST_STAGE) begin
                            state_s = DONE;
                            done_s  = 1'b1;
                        end else begin
                            stage_s = stage_r + SW'(1);
                        end
                    end else if (cnt_tc_s) begin
                        state_s   = FAULT;
                        fault_s   = 1'b1;
                        fstage_s  = stage_r;
                        cnt_clr_s = 1'b1;
                    end else begin
                        cnt_en_s  = 1'b1;
                    end
                end
                DONE: begin
`ifdef RESET_SEQ_WATCHDOG_EN
                    if (wdt_tc_s && !bus.i_wdt_kick) begin
                        state_s   = ASSERT;
                        stage_s   = '0;
                        done_s    = 1'b0;
                        fault_s   = 1'b0;
                        fstage_s  = '0;
                        cnt_clr_s = 1'b1;
                        bite_s    = 1'b1;
                    end else begin
                        done_s    = 1'b1;
                    end
`else
                    done_s = 1'b1;
`endif
                end
                FAULT: begin
                    fault_s = 1'b1;
                end
                default: begin
                    state_s   = ASSERT;
                    stage_s   = '0;
                    done_s    = 1'b0;
                    fault_s   = 1'b0;
                    fstage_s  = '0;
                    cnt_clr_s = 1'b1;
                end
            endcase
        end

        // o_reset is derived only from (state, stage), so it is always a thermometer code.
        reset_s = '1;
        for (int j = 0; j < STAGES; j++) begin
            case (state_s)
                ASSERT:  reset_s[j] = 1'b1;
                WAIT:    reset_s[j] = (j <= int'(stage_s)) ? 1'b0 : 1'b1;
                DONE:    reset_s[j] = 1'b0;
                FAULT:   reset_s[j] = (j < int'(stage_s)) ? 1'b0 : 1'b1;
                default: reset_s[j] = 1'b1;
            endcase
        end
    end

    // State and output registers; i_reset overrides everything.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r  <= ASSERT;
            stage_r  <= '0;
            reset_r  <= '1;
            done_r   <= 1'b0;
            fault_r  <= 1'b0;
            fstage_r <= '0;
`ifdef RESET_SEQ_WATCHDOG_EN
            bite_r   <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            stage_r  <= stage_s;
            reset_r  <= reset_s;
            done_r   <= done_s;
            fault_r  <= fault_s;
            fstage_r <= fstage_s;
`ifdef RESET_SEQ_WATCHDOG_EN
            bite_r   <= bite_s;
`endif
        end
    end

    assign bus.o_reset       = reset_r;
    assign bus.o_done        = done_r;
    assign bus.o_fault       = fault_r;
    assign bus.o_fault_stage = fstage_r;
endmodule
